gtp_rx_link_ctrl: RTL and testbench

- RX link-synchronisation controller for the 16-bit 8b/10b GTP receive path, in the rx_clk domain behind the transceiver wrapper.
- Drives comma-alignment enables: on while hunting, frozen once linked.
- Qualifies received words with data_valid and tracks code errors through a leaky error budget.
- Requests a transceiver soft reset after repeated failed acquisition attempts.

---
 rtl/gtp_link_pkg.sv | 24 ++
 rtl/gtp_err_budget.sv | 74 +++++++
 rtl/gtp_rx_link_ctrl.sv | 177 +++++++++++++++++
 tb/tb_gtp_rx_link_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gtp_link_pkg.sv
// -----------------------------------------------------------------------------
// gtp_link_pkg
// Shared types and helpers for the GTP RX link-synchronisation controller.
//   link_state_t : controller state, encoding visible on the link_state port
//   K28_5        : comma character used for word alignment
//   cnt_w()      : width of a counter that must hold 0..max_val
// -----------------------------------------------------------------------------
package gtp_link_pkg;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_ACQ     = 2'd1,
      ST_LINKED  = 2'd2,
      ST_RST_REQ = 2'd3
   } link_state_t;

   localparam logic [7:0] K28_5 = 8'hBC;

   // Never returns 0 so a degenerate parameter still yields a legal vector.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/gtp_err_budget.sv
// -----------------------------------------------------------------------------
// gtp_err_budget
// Leaky error counter. Each errored word adds one to the budget; every
// GOOD_DECAY consecutive clean words remove one. An error in the word that
// would have completed a decay run wins: increment, no decay.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_enable      : count this cycle's word (only while linked)
//   i_clear       : restart the budget (link entry)
//   i_err         : current word carries a code error
//   o_err_cnt     : current budget level, saturates at ERR_LIMIT
//   o_limit_hit   : current word takes the budget to ERR_LIMIT
// -----------------------------------------------------------------------------
module gtp_err_budget
   import gtp_link_pkg::*;
#(
   parameter int ERR_LIMIT  = 4,
   parameter int GOOD_DECAY = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_enable,
   input  logic                          i_clear,
   input  logic                          i_err,
   output logic [cnt_w(ERR_LIMIT)-1:0]   o_err_cnt,
   output logic                          o_limit_hit
);

   localparam int EW = cnt_w(ERR_LIMIT);
   localparam int CW = cnt_w(GOOD_DECAY);
   localparam logic [EW-1:0] ERR_MAX    = EW'(ERR_LIMIT);
   localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_LIMIT - 1);
   localparam logic [CW-1:0] DECAY_LAST = CW'(GOOD_DECAY - 1);

   logic [CW-1:0] r_clean_cnt;
   logic [CW-1:0] w_clean_nxt;
   logic [EW-1:0] w_err_nxt;

   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      w_err_nxt   = o_err_cnt;
      w_clean_nxt = r_clean_cnt;
      if (i_clear) begin
         w_err_nxt   = '0;
         w_clean_nxt = '0;
      end else if (i_enable) begin
         if (i_err) begin
            if (o_err_cnt != ERR_MAX) w_err_nxt = o_err_cnt + 1'b1;
            w_clean_nxt = '0;
         end else if (r_clean_cnt == DECAY_LAST) begin
            if (o_err_cnt != '0) w_err_nxt = o_err_cnt - 1'b1;
            w_clean_nxt = '0;
         end else begin
            w_clean_nxt = r_clean_cnt + 1'b1;
         end
      end
   end

   // Looks at the registered level only (not i_clear) so the controller's
   // next-state logic cannot form a combinational loop through this output.
   assign o_limit_hit = i_enable && i_err && (o_err_cnt == ERR_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_err_cnt   <= '0;
         r_clean_cnt <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         o_err_cnt   <= w_err_nxt;
         r_clean_cnt <= w_clean_nxt;
      end
   end

endmodule

// File: rtl/gtp_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// gtp_rx_link_ctrl
// RX link-synchronisation controller for the 16-bit 8b/10b GTP receive path.
// Hunts for aligned K28.5 commas, declares link after COMMA_GOOD_CNT of them,
// freezes comma alignment while linked, qualifies data with data_valid and
// drops the link on realignment or an exhausted error budget. After
// MAX_RETRIES timed-out acquisition attempts it pulses soft_reset_req.
// Ports:
//   rx_clk, rxresetdone        : usrclk2, asynchronous active-low reset
//   i_rx_data/i_rxcharisk      : decoded word, byte 0 in [7:0]
//   i_rxdisperr/i_rxnotintable : per-byte code violations
//   i_rxbyteisaligned/realign  : GT alignment status / realignment pulse
//   o_comma_align_en           : drives rxmcommaalignen and rxpcommaalignen
//   o_link_up, o_link_state    : LINKED flag, raw state encoding
//   o_data_valid, o_rx_data_out, o_rxcharisk_out : registered datapath
//   o_soft_reset_req           : RESET_PULSE-cycle request to the GT
//   o_resync_count             : saturating count of link drops
// -----------------------------------------------------------------------------
module gtp_rx_link_ctrl
   import gtp_link_pkg::*;
#(
   parameter int COMMA_GOOD_CNT = 4,
   parameter int ERR_LIMIT      = 4,
   parameter int GOOD_DECAY     = 16,
   parameter int HUNT_TIMEOUT   = 65535,
   parameter int MAX_RETRIES    = 3,
   parameter int RESET_PULSE    = 16
) (
   input  logic        rx_clk,
   input  logic        rxresetdone,
   input  logic [15:0] i_rx_data,
   input  logic [1:0]  i_rxcharisk,
   input  logic [1:0]  i_rxdisperr,
   input  logic [1:0]  i_rxnotintable,
   input  logic        i_rxbyteisaligned,
   input  logic        i_rxbyterealign,
   output logic        o_comma_align_en,
   output logic        o_link_up,
   output logic        o_data_valid,
   output logic [15:0] o_rx_data_out,
   output logic [1:0]  o_rxcharisk_out,
   output logic        o_soft_reset_req,
   output logic [1:0]  o_link_state,
   output logic [7:0]  o_resync_count
);

   localparam int TW = cnt_w(HUNT_TIMEOUT);
   localparam int RW = cnt_w(MAX_RETRIES);
   localparam int GW = cnt_w(COMMA_GOOD_CNT);
   localparam int PW = cnt_w(RESET_PULSE);
   localparam logic [TW-1:0] TMR_LAST   = TW'(HUNT_TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
   localparam logic [GW-1:0] GOOD_LAST  = GW'(COMMA_GOOD_CNT - 1);
   localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE - 1);

   link_state_t   r_state,      w_state_nxt;
   logic [TW-1:0] r_hunt_tmr,   w_hunt_tmr_nxt;
   logic [RW-1:0] r_retry_cnt,  w_retry_nxt;
   logic [GW-1:0] r_good_cnt,   w_good_nxt;
   logic [PW-1:0] r_pulse_cnt,  w_pulse_nxt;
   logic [7:0]    r_resync_cnt, w_resync_nxt;

   logic w_comma_ok, w_code_err, w_align_lost, w_timeout;
   logic w_err_limit, w_linked_exit, w_enter_linked;

   // A comma landing in byte 1 means the word boundary is off by one byte.
   assign w_code_err    = (|i_rxdisperr) || (|i_rxnotintable) ||
                          ((i_rx_data[15:8] == K28_5) && i_rxcharisk[1]);
   assign w_comma_ok    = (i_rx_data[7:0] == K28_5) && (i_rxcharisk == 2'b01) &&
                          i_rxbyteisaligned;
   assign w_align_lost  = i_rxbyterealign || !i_rxbyteisaligned;
   assign w_timeout     = (r_hunt_tmr == TMR_LAST);
   assign w_linked_exit = (r_state == ST_LINKED) && (w_align_lost || w_err_limit);
   assign w_enter_linked = (r_state != ST_LINKED) && (w_state_nxt == ST_LINKED);

   gtp_err_budget #(
      .ERR_LIMIT  (ERR_LIMIT),
      .GOOD_DECAY (GOOD_DECAY)
   ) u_err_budget (
      .clk         (rx_clk),
      .rst_n       (rxresetdone),
      .i_enable    (r_state == ST_LINKED),
      .i_clear     (w_enter_linked),
      .i_err       (w_code_err),
      .o_err_cnt   (),
      .o_limit_hit (w_err_limit)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_hunt_tmr_nxt = r_hunt_tmr;
      w_retry_nxt    = r_retry_cnt;
      w_good_nxt     = r_good_cnt;
      w_pulse_nxt    = r_pulse_cnt;
      w_resync_nxt   = r_resync_cnt;
      case (r_state)
         ST_HUNT, ST_ACQ: begin
            // The attempt timer spans HUNT and ACQ; falling back to HUNT does
            // not restart it, so a flapping link still runs out of attempts.
            if (w_timeout) begin
               w_hunt_tmr_nxt = '0;
               w_retry_nxt    = r_retry_cnt + 1'b1;
            end else begin
               w_hunt_tmr_nxt = r_hunt_tmr + 1'b1;
            end
            if (w_timeout && (r_retry_cnt == RETRY_LAST)) begin
               w_state_nxt = ST_RST_REQ;
               w_good_nxt  = '0;
               w_pulse_nxt = '0;
            end else if (r_state == ST_HUNT) begin
               if (w_comma_ok && !w_code_err) begin
                  w_state_nxt = ST_ACQ;
                  w_good_nxt  = GW'(1);
               end
            end else if (w_code_err || w_align_lost) begin
               w_state_nxt = ST_HUNT;
               w_good_nxt  = '0;
            end else if (w_comma_ok) begin
               w_good_nxt = r_good_cnt + 1'b1;
               if (r_good_cnt == GOOD_LAST) begin
                  w_state_nxt    = ST_LINKED;
                  w_retry_nxt    = '0;
                  w_hunt_tmr_nxt = '0;
               end
            end
         end
         ST_LINKED: begin
            if (w_linked_exit) begin
               w_state_nxt = ST_HUNT;
               w_good_nxt  = '0;
               if (r_resync_cnt != 8'hFF) w_resync_nxt = r_resync_cnt + 1'b1;
            end
         end
         ST_RST_REQ: begin
            if (r_pulse_cnt == PULSE_LAST) begin
               w_state_nxt = ST_HUNT;
               w_retry_nxt = '0;
               w_pulse_nxt = '0;
            end else begin
               w_pulse_nxt = r_pulse_cnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge rx_clk or negedge rxresetdone) begin
      if (!rxresetdone) begin
         r_state         <= ST_HUNT;
         r_hunt_tmr      <= '0;
         r_retry_cnt     <= '0;
         r_good_cnt      <= '0;
         r_pulse_cnt     <= '0;
         r_resync_cnt    <= '0;
         o_data_valid    <= 1'b0;
         o_rx_data_out   <= '0;
         o_rxcharisk_out <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_hunt_tmr      <= w_hunt_tmr_nxt;
         r_retry_cnt     <= w_retry_nxt;
         r_good_cnt      <= w_good_nxt;
         r_pulse_cnt     <= w_pulse_nxt;
         r_resync_cnt    <= w_resync_nxt;
         // The word that drops the link is never marked valid.
         o_data_valid    <= (r_state == ST_LINKED) && !w_code_err && !w_linked_exit;
         o_rx_data_out   <= i_rx_data;
         o_rxcharisk_out <= i_rxcharisk;
      end
   end

   assign o_link_state     = r_state;
   assign o_link_up        = (r_state == ST_LINKED);
   assign o_comma_align_en = (r_state == ST_HUNT) || (r_state == ST_ACQ);
   assign o_soft_reset_req = (r_state == ST_RST_REQ);
   assign o_resync_count   = r_resync_cnt;

endmodule

// File: tb/tb_gtp_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gtp_rx_link_ctrl
// Directed bench for gtp_rx_link_ctrl (HUNT_TIMEOUT shortened to 100).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_gtp_rx_link_ctrl;

   localparam logic [15:0] COMMA  = 16'h50BC;
   localparam logic [15:0] FILL   = 16'h1234;
   localparam logic [15:0] BADCOM = 16'hBC50;

   logic        rx_clk = 1'b0;
   logic        rxresetdone = 1'b0;
   logic [15:0] rx_data = '0;
   logic [1:0]  rxcharisk = '0, rxdisperr = '0, rxnotintable = '0;
   logic        rxbyteisaligned = 1'b1, rxbyterealign = 1'b0;
   logic        comma_align_en, link_up, data_valid, soft_reset_req;
   logic [15:0] rx_data_out;
   logic [1:0]  rxcharisk_out, link_state;
   logic [7:0]  resync_count;

   int n_checks = 0;
   int n_errors = 0;

   gtp_rx_link_ctrl #(.HUNT_TIMEOUT(100)) dut (
      .rx_clk            (rx_clk),
      .rxresetdone       (rxresetdone),
      .i_rx_data         (rx_data),
      .i_rxcharisk       (rxcharisk),
      .i_rxdisperr       (rxdisperr),
      .i_rxnotintable    (rxnotintable),
      .i_rxbyteisaligned (rxbyteisaligned),
      .i_rxbyterealign   (rxbyterealign),
      .o_comma_align_en  (comma_align_en),
      .o_link_up         (link_up),
      .o_data_valid      (data_valid),
      .o_rx_data_out     (rx_data_out),
      .o_rxcharisk_out   (rxcharisk_out),
      .o_soft_reset_req  (soft_reset_req),
      .o_link_state      (link_state),
      .o_resync_count    (resync_count)
   );

   always #5 rx_clk = ~rx_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Present one word for one clock, return 1 ns after the sampling edge.
   task automatic put(input logic [15:0] d, input logic [1:0] k,
                      input logic [1:0] de = 2'b00, input logic al = 1'b1,
                      input logic rl = 1'b0);
      rx_data         = d;
      rxcharisk       = k;
      rxdisperr       = de;
      rxnotintable    = 2'b00;
      rxbyteisaligned = al;
      rxbyterealign   = rl;
      @(posedge rx_clk);
      #1;
   endtask

   task automatic acquire();
      for (int i = 0; i < 3; i++) begin
         put(COMMA, 2'b01);
         put(FILL, 2'b00);
      end
      put(COMMA, 2'b01);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int hi;
      // ---- reset state
      repeat (3) @(posedge rx_clk);
      #1;
      check("rst_state", link_state, 0);
      check("rst_comma_en", comma_align_en, 1);
      check("rst_link_up", link_up, 0);
      check("rst_valid", data_valid, 0);
      check("rst_soft", soft_reset_req, 0);
      check("rst_resync", resync_count, 0);
      rxresetdone = 1'b1;

      // ---- 1: acquisition with commas every second word
      for (int i = 0; i < 3; i++) begin
         put(COMMA, 2'b01);
         put(FILL, 2'b00);
      end
      check("t1_acq_state", link_state, 1);
      check("t1_acq_comma_en", comma_align_en, 1);
      put(COMMA, 2'b01);
      check("t1_link_up", link_up, 1);
      check("t1_comma_en_off", comma_align_en, 0);
      check("t1_state_linked", link_state, 2);
      check("t1_comma_not_valid", data_valid, 0);
      check("t1_data_dly", rx_data_out, COMMA);
      check("t1_k_dly", rxcharisk_out, 2'b01);
      put(16'h3C7E, 2'b00);
      check("t1_valid", data_valid, 1);
      check("t1_data", rx_data_out, 16'h3C7E);
      check("t1_k", rxcharisk_out, 0);

      // ---- 2: four spaced errors drop the link
      for (int e = 1; e <= 4; e++) begin
         put(FILL, 2'b00, 2'b01);
         check("t2_err_cnt", dut.u_err_budget.o_err_cnt, e);
         check("t2_err_not_valid", data_valid, 0);
         if (e < 4) begin
            check("t2_still_up", link_up, 1);
            for (int c = 0; c < 5; c++) put(FILL, 2'b00);
            check("t2_clean_valid", data_valid, 1);
         end
      end
      check("t2_link_down", link_up, 0);
      check("t2_state_hunt", link_state, 0);
      check("t2_resync", resync_count, 1);
      check("t2_comma_en", comma_align_en, 1);

      // ---- 3: leaky decay, error beats decay
      acquire();
      check("t3_link_up", link_up, 1);
      check("t3_budget_cleared", dut.u_err_budget.o_err_cnt, 0);
      put(FILL, 2'b00, 2'b10);
      check("t3_err1", dut.u_err_budget.o_err_cnt, 1);
      repeat (15) put(FILL, 2'b00);
      check("t3_no_decay_15", dut.u_err_budget.o_err_cnt, 1);
      put(FILL, 2'b00);
      check("t3_decay_16", dut.u_err_budget.o_err_cnt, 0);
      put(FILL, 2'b00, 2'b01);
      repeat (15) put(FILL, 2'b00);
      put(FILL, 2'b00, 2'b01);
      check("t3_err_wins", dut.u_err_budget.o_err_cnt, 2);
      check("t3_still_up", link_up, 1);

      // ---- 5: realign during ACQ restarts the comma count
      put(FILL, 2'b00, 2'b00, 1'b0);
      check("t5_unaligned_hunt", link_state, 0);
      check("t5_resync", resync_count, 2);
      put(COMMA, 2'b01);
      put(FILL, 2'b00);
      put(COMMA, 2'b01);
      check("t5_acq", link_state, 1);
      check("t5_good2", dut.r_good_cnt, 2);
      put(FILL, 2'b00, 2'b00, 1'b1, 1'b1);
      check("t5_realign_hunt", link_state, 0);
      check("t5_good0", dut.r_good_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         put(COMMA, 2'b01);
         put(FILL, 2'b00);
      end
      check("t5_three_not_linked", link_up, 0);
      check("t5_good3", dut.r_good_cnt, 3);
      put(COMMA, 2'b01);
      check("t5_fourth_links", link_up, 1);

      // ---- 4: byte-1 commas, timeouts and soft reset
      put(FILL, 2'b00, 2'b00, 1'b0);
      check("t4_resync", resync_count, 3);
      repeat (99) put(BADCOM, 2'b10);
      check("t4_retry0", dut.r_retry_cnt, 0);
      put(BADCOM, 2'b10);
      check("t4_retry1", dut.r_retry_cnt, 1);
      repeat (99) put(BADCOM, 2'b10);
      check("t4_hunt_199", link_state, 0);
      put(BADCOM, 2'b10);
      check("t4_retry2", dut.r_retry_cnt, 2);
      repeat (99) put(BADCOM, 2'b10);
      check("t4_soft_low_299", soft_reset_req, 0);
      put(BADCOM, 2'b10);
      check("t4_rst_req", link_state, 3);
      check("t4_soft_high", soft_reset_req, 1);
      hi = 1;
      for (int i = 0; i < 40 && soft_reset_req; i++) begin
         put(BADCOM, 2'b10);
         if (soft_reset_req) hi++;
      end
      check("t4_pulse_width", hi, 16);
      check("t4_back_hunt", link_state, 0);
      check("t4_retry_clr", dut.r_retry_cnt, 0);
      check("t4_comma_en", comma_align_en, 1);

      // ---- 6a: async reset while linked
      acquire();
      put(FILL, 2'b00);
      check("t6_pre_valid", data_valid, 1);
      #3 rxresetdone = 1'b0;
      #1;
      check("t6_lk_state", link_state, 0);
      check("t6_lk_link_up", link_up, 0);
      check("t6_lk_comma_en", comma_align_en, 1);
      check("t6_lk_valid", data_valid, 0);
      check("t6_lk_data", rx_data_out, 0);
      check("t6_lk_resync", resync_count, 0);
      #2 rxresetdone = 1'b1;

      // ---- 6b: async reset mid soft-reset pulse
      repeat (300) put(BADCOM, 2'b10);
      check("t6_rq_state", link_state, 3);
      repeat (5) put(BADCOM, 2'b10);
      check("t6_rq_soft_mid", soft_reset_req, 1);
      #3 rxresetdone = 1'b0;
      #1;
      check("t6_rq_soft", soft_reset_req, 0);
      check("t6_rq_state0", link_state, 0);
      check("t6_rq_comma_en", comma_align_en, 1);
      check("t6_rq_retry", dut.r_retry_cnt, 0);
      #2 rxresetdone = 1'b1;
      repeat (4) put(FILL, 2'b00);
      check("t6_after_soft", soft_reset_req, 0);
      check("t6_after_state", link_state, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
